// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared constants and types for the integer write-back arbiter.
// Widths mirror the core's `E203_XLEN / `E203_RFIDX_WIDTH defaults.
package e203_exu_wbck_arb_pkg;

    localparam int WBCK_XLEN    = 32;
    localparam int WBCK_RFIDX_W = 5;
    localparam int WBCK_DEPTH   = 2;

    typedef enum logic [0:0] {
        SEL_ALU  = 1'b0,
        SEL_LNGP = 1'b1
    } wbck_sel_e;

endpackage

// File: rtl/e203_exu_wbck_fifo.sv
// DEPTH-entry valid/ready FIFO buffering long-pipe write-back results.
// Exposes per-entry valid bits and payloads for the hazard lookup.
module e203_exu_wbck_fifo
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int DEPTH = WBCK_DEPTH,
    parameter int EW    = 1 + WBCK_RFIDX_W + WBCK_XLEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [EW-1:0]       i_dat,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [EW-1:0]       o_dat,
    output logic [DEPTH-1:0]    ent_vld,
    output logic [DEPTH*EW-1:0] ent_dat,
    output logic                empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] vld_nxt_s;
    logic             enq_s;
    logic             deq_s;
    logic             rst_n_s;

    // ready depends on registered count only, never on the dequeue side
    assign i_ready = (cnt_r != CNT_W'(DEPTH));
    assign enq_s   = i_valid & i_ready;
    assign o_valid = vld_r[rd_ptr_r];
    assign deq_s   = o_valid & o_ready;
    assign empty   = (cnt_r == {CNT_W{1'b0}});
    assign ent_vld = vld_r;
    assign o_dat   = ent_dat[rd_ptr_r*EW +: EW];
    assign rst_n_s = ~rst;

    // next-state of per-entry valid bits
    always_comb begin
        vld_nxt_s = vld_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_s && (wr_ptr_r == PTR_W'(i))) begin
                vld_nxt_s[i] = 1'b1;
            end else if (deq_s && (rd_ptr_r == PTR_W'(i))) begin
                vld_nxt_s[i] = 1'b0;
            end else begin
                vld_nxt_s[i] = vld_r[i];
            end
        end
    end

    // pointers, occupancy and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            vld_r    <= {DEPTH{1'b0}};
        end else begin
            vld_r <= vld_nxt_s;
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({enq_s, deq_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_ent
            sirv_gnrl_dfflr #(.DW(EW)) u_ent (
                .lden  (enq_s & (wr_ptr_r == PTR_W'(g))),
                .dnxt  (i_dat),
                .qout  (ent_dat[g*EW +: EW]),
                .clk   (clk),
                .rst_n (rst_n_s)
            );
        end
    endgenerate

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// General load-enabled flop with asynchronous active-low reset (storage cell).
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    logic [DW-1:0] qout_r;

    // hold value unless loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_r <= {DW{1'b0}};
        end else if (lden) begin
            qout_r <= dnxt;
        end
    end

    assign qout = qout_r;

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Integer regfile write-back arbiter: buffered long-pipe results win over ALU.
// Optional source hazard lookup enabled by E203_WBCK_HAZARD_EN.
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int DEPTH   = WBCK_DEPTH,
    parameter int XLEN    = WBCK_XLEN,
    parameter int RFIDX_W = WBCK_RFIDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic               alu_wbck_rdwen,
    input  logic [RFIDX_W-1:0] alu_wbck_rdidx,
    input  logic [XLEN-1:0]    alu_wbck_wdat,
    input  logic               lngp_wbck_valid,
    output logic               lngp_wbck_ready,
    input  logic               lngp_wbck_rdwen,
    input  logic [RFIDX_W-1:0] lngp_wbck_rdidx,
    input  logic [XLEN-1:0]    lngp_wbck_wdat,
    output logic               rf_wbck_wen,
    output logic [RFIDX_W-1:0] rf_wbck_idx,
    output logic [XLEN-1:0]    rf_wbck_dat,
    input  logic [RFIDX_W-1:0] hzd_src1_idx,
    input  logic [RFIDX_W-1:0] hzd_src2_idx,
    output logic               hzd_src1_pend,
    output logic               hzd_src2_pend,
    output logic               buf_empty
);

    localparam int EW = 1 + RFIDX_W + XLEN;

    logic                  head_valid_s;
    logic [EW-1:0]         head_s;
    logic [DEPTH-1:0]      ent_vld_s;
    logic [DEPTH*EW-1:0]   ent_dat_s;
    wbck_sel_e             sel_s;
    logic                  sel_valid_s;
    logic                  sel_rdwen_s;
    logic [RFIDX_W-1:0]    sel_idx_s;
    logic [XLEN-1:0]       sel_dat_s;
    logic                  unused_ent_s;

    // head is always consumed, so the FIFO read side is tied ready
    e203_exu_wbck_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_valid (lngp_wbck_valid),
        .i_ready (lngp_wbck_ready),
        .i_dat   ({lngp_wbck_rdwen, lngp_wbck_rdidx, lngp_wbck_wdat}),
        .o_valid (head_valid_s),
        .o_ready (1'b1),
        .o_dat   (head_s),
        .ent_vld (ent_vld_s),
        .ent_dat (ent_dat_s),
        .empty   (buf_empty)
    );

    assign sel_s          = head_valid_s ? SEL_LNGP : SEL_ALU;
    assign alu_wbck_ready = (sel_s == SEL_ALU);

    // write-port source mux
    always_comb begin
        sel_valid_s = alu_wbck_valid;
        sel_rdwen_s = alu_wbck_rdwen;
        sel_idx_s   = alu_wbck_rdidx;
        sel_dat_s   = alu_wbck_wdat;
        case (sel_s)
            SEL_LNGP: begin
                sel_valid_s = 1'b1;
                {sel_rdwen_s, sel_idx_s, sel_dat_s} = head_s;
            end
            SEL_ALU: begin
                sel_valid_s = alu_wbck_valid;
                sel_rdwen_s = alu_wbck_rdwen;
                sel_idx_s   = alu_wbck_rdidx;
                sel_dat_s   = alu_wbck_wdat;
            end
            default: begin
                sel_valid_s = alu_wbck_valid;
                sel_rdwen_s = alu_wbck_rdwen;
                sel_idx_s   = alu_wbck_rdidx;
                sel_dat_s   = alu_wbck_wdat;
            end
        endcase
    end

    // x0 is hardwired zero, so writes to it are dropped here
    assign rf_wbck_wen = sel_valid_s & sel_rdwen_s & (sel_idx_s != {RFIDX_W{1'b0}});
    assign rf_wbck_idx = sel_idx_s;
    assign rf_wbck_dat = sel_dat_s;

    // data payloads are only partially inspected by the hazard lookup
    assign unused_ent_s = ^ent_dat_s;

`ifdef E203_WBCK_HAZARD_EN
    // match decode sources against every buffered rd
    always_comb begin
        hzd_src1_pend = 1'b0;
        hzd_src2_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hzd_src1_pend = hzd_src1_pend | (ent_vld_s[i] & ent_dat_s[i*EW + EW - 1]
                          & (ent_dat_s[i*EW + XLEN +: RFIDX_W] == hzd_src1_idx)
                          & (hzd_src1_idx != {RFIDX_W{1'b0}}));
            hzd_src2_pend = hzd_src2_pend | (ent_vld_s[i] & ent_dat_s[i*EW + EW - 1]
                          & (ent_dat_s[i*EW + XLEN +: RFIDX_W] == hzd_src2_idx)
                          & (hzd_src2_idx != {RFIDX_W{1'b0}}));
        end
    end
`else
    logic unused_hzd_s;
    assign unused_hzd_s  = ^{hzd_src1_idx, hzd_src2_idx, ent_vld_s};
    assign hzd_src1_pend = 1'b0;
    assign hzd_src2_pend = 1'b0;
`endif

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Self-checking bench: directed vector table, hazard/reset sequences, random scoreboard run.
module tb_e203_exu_wbck_arb;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            alu_wbck_valid, alu_wbck_ready, alu_wbck_rdwen;
    logic [RW-1:0]   alu_wbck_rdidx;
    logic [XLEN-1:0] alu_wbck_wdat;
    logic            lngp_wbck_valid, lngp_wbck_ready, lngp_wbck_rdwen;
    logic [RW-1:0]   lngp_wbck_rdidx;
    logic [XLEN-1:0] lngp_wbck_wdat;
    logic            rf_wbck_wen;
    logic [RW-1:0]   rf_wbck_idx;
    logic [XLEN-1:0] rf_wbck_dat;
    logic [RW-1:0]   hzd_src1_idx, hzd_src2_idx;
    logic            hzd_src1_pend, hzd_src2_pend, buf_empty;

    e203_exu_wbck_arb dut (
        .clk(clk), .rst(rst),
        .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
        .alu_wbck_rdwen(alu_wbck_rdwen), .alu_wbck_rdidx(alu_wbck_rdidx),
        .alu_wbck_wdat(alu_wbck_wdat),
        .lngp_wbck_valid(lngp_wbck_valid), .lngp_wbck_ready(lngp_wbck_ready),
        .lngp_wbck_rdwen(lngp_wbck_rdwen), .lngp_wbck_rdidx(lngp_wbck_rdidx),
        .lngp_wbck_wdat(lngp_wbck_wdat),
        .rf_wbck_wen(rf_wbck_wen), .rf_wbck_idx(rf_wbck_idx), .rf_wbck_dat(rf_wbck_dat),
        .hzd_src1_idx(hzd_src1_idx), .hzd_src2_idx(hzd_src2_idx),
        .hzd_src1_pend(hzd_src1_pend), .hzd_src2_pend(hzd_src2_pend),
        .buf_empty(buf_empty)
    );

    typedef struct {
        logic av, ar; logic [RW-1:0] ai; logic [XLEN-1:0] ad;
        logic lv, lr; logic [RW-1:0] li; logic [XLEN-1:0] ld;
        logic e_ar, e_lr, e_wen; logic [RW-1:0] e_idx; logic [XLEN-1:0] e_dat; logic e_emp;
    } vec_t;

    vec_t vecs [14];
    logic [RW+XLEN-1:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic ar, input logic [RW-1:0] ai, input logic [XLEN-1:0] ad,
                         input logic lv, input logic lr, input logic [RW-1:0] li, input logic [XLEN-1:0] ld);
        alu_wbck_valid  = av; alu_wbck_rdwen  = ar; alu_wbck_rdidx  = ai; alu_wbck_wdat  = ad;
        lngp_wbck_valid = lv; lngp_wbck_rdwen = lr; lngp_wbck_rdidx = li; lngp_wbck_wdat = ld;
    endtask

    initial begin
        logic hz_en;
        logic [RW+XLEN-1:0] e;
        int mcnt;
        logic lg_hs;
`ifdef E203_WBCK_HAZARD_EN
        hz_en = 1'b1;
`else
        hz_en = 1'b0;
`endif
        // ALU pass-through, long-pipe priority, back-to-back long-pipe, x0/rdwen=0 cases
        vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b1, 5'd5,  32'h1234, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd7, 32'hA5A5,    1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b1};
        vecs[2]  = '{1'b1, 1'b1, 5'd3, 32'h3333, 1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 5'd7,  32'hA5A5, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 5'd3, 32'h3333, 1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b1, 5'd3,  32'h3333, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd10, 32'h10,     1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b1};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd11, 32'h11,     1'b0, 1'b1, 1'b1, 5'd10, 32'h10,   1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd12, 32'h12,     1'b0, 1'b1, 1'b1, 5'd11, 32'h11,   1'b0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 5'd12, 32'h12,   1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b1};
        vecs[9]  = '{1'b1, 1'b0, 5'd4, 32'h44,   1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd4, 32'h44,   1'b1};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b1};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd9, 32'h99,      1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b0, 5'd9,  32'h99,   1'b0};

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        hzd_src1_idx = 5'd0;
        hzd_src2_idx = 5'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_buf_empty", buf_empty, 1'b1);
        chk("rst_lngp_ready", lngp_wbck_ready, 1'b1);
        chk("rst_wen", rf_wbck_wen, 1'b0);
        chk("rst_idx", rf_wbck_idx, 5'd0);
        chk("rst_dat", rf_wbck_dat, 32'h0);
        chk("rst_pend1", hzd_src1_pend, 1'b0);
        chk("rst_pend2", hzd_src2_pend, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ai, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].li, vecs[i].ld);
            @(negedge clk);
            chk($sformatf("vec%0d_alu_ready", i), alu_wbck_ready, vecs[i].e_ar);
            chk($sformatf("vec%0d_lngp_ready", i), lngp_wbck_ready, vecs[i].e_lr);
            chk($sformatf("vec%0d_wen", i), rf_wbck_wen, vecs[i].e_wen);
            chk($sformatf("vec%0d_idx", i), rf_wbck_idx, vecs[i].e_idx);
            chk($sformatf("vec%0d_dat", i), rf_wbck_dat, vecs[i].e_dat);
            chk($sformatf("vec%0d_empty", i), buf_empty, vecs[i].e_emp);
            @(posedge clk); #1;
        end

        // hazard lookup against a buffered rd=9
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 32'h9);
        hzd_src1_idx = 5'd9;
        hzd_src2_idx = 5'd0;
        @(negedge clk);
        chk("hzd_pend1_before_enq", hzd_src1_pend, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("hzd_pend1_buffered", hzd_src1_pend, hz_en);
        chk("hzd_pend2_x0", hzd_src2_pend, 1'b0);
        chk("hzd_write_idx", rf_wbck_idx, 5'd9);
        chk("hzd_write_wen", rf_wbck_wen, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hzd_pend1_drained", hzd_src1_pend, 1'b0);
        chk("hzd_empty_drained", buf_empty, 1'b1);
        hzd_src1_idx = 5'd0;

        // asynchronous reset with a buffered entry
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd6, 32'h66);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("arst_pre_nonempty", buf_empty, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_empty", buf_empty, 1'b1);
        chk("arst_lngp_ready", lngp_wbck_ready, 1'b1);
        chk("arst_wen", rf_wbck_wen, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("arst_no_stale_wen", rf_wbck_wen, 1'b0);
        chk("arst_still_empty", buf_empty, 1'b1);
        @(posedge clk); #1;

        // random traffic against an in-order write scoreboard
        mcnt = 0;
        for (int c = 0; c < 408; c++) begin
            if (c < 400) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            end else begin
                drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
            end
            @(negedge clk);
            chk("rnd_alu_ready", alu_wbck_ready, (mcnt == 0));
            chk("rnd_lngp_ready", lngp_wbck_ready, (mcnt != DEPTH));
            chk("rnd_buf_empty", buf_empty, (mcnt == 0));
            if (alu_wbck_valid && (mcnt == 0) && alu_wbck_rdwen && (alu_wbck_rdidx != 5'd0))
                exp_q.push_back({alu_wbck_rdidx, alu_wbck_wdat});
            if (rf_wbck_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_extra_write actual=idx%0d required=no_write at %0t", rf_wbck_idx, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_idx", rf_wbck_idx, e[RW+XLEN-1:XLEN]);
                    chk("rnd_dat", rf_wbck_dat, e[XLEN-1:0]);
                end
            end
            lg_hs = lngp_wbck_valid && (mcnt != DEPTH);
            if (lg_hs && lngp_wbck_rdwen && (lngp_wbck_rdidx != 5'd0))
                exp_q.push_back({lngp_wbck_rdidx, lngp_wbck_wdat});
            mcnt = mcnt + int'(lg_hs) - int'(mcnt != 0);
            @(posedge clk); #1;
        end
        chk("rnd_drain_missing_writes", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
